load_mem_ctrl: RTL and testbench

Memory-side responder for the load execution path. Accepts address-computed load packets (EX_LSQ_PACKET) from the load FU and buffers them in a small in-order queue. Issues each load to the data-memory port, matches tagged responses, then size-selects and sign-/zero-extends the returned data. Presents completions in program order as an FU_EX_PACKET that is held until acknowledged.

---
 rtl/sys_defs.sv | 56 +++++
 rtl/load_data_align.sv | 29 ++
 rtl/load_mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_load_mem_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared types for the load/store path: bus commands, access sizes, FU packets
// and the load-queue entry layout.
package sys_defs;

  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 5;
  localparam int MEM_TAG_W = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      alu_result;
    logic [2:0]           mem_size;
    logic [ROB_TAG_W-1:0] tag;
  } EX_LSQ_PACKET;

  typedef struct packed {
    logic                 done;
    logic [XLEN-1:0]      v;
    logic [ROB_TAG_W-1:0] rob_tag;
  } FU_EX_PACKET;

  typedef enum logic [1:0] {
    LQ_WAIT_ISSUE = 2'h0,
    LQ_WAIT_DATA  = 2'h1,
    LQ_DONE       = 2'h2
  } LQ_STATE;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      addr;
    logic [2:0]           mem_size;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [MEM_TAG_W-1:0] mem_tag;
    logic [XLEN-1:0]      data;
    LQ_STATE              state;
  } LQ_ENTRY;

  // The data port only moves whole doublewords.
  function automatic logic [XLEN-1:0] dword_addr(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/load_data_align.sv
// Picks the addressed byte/half/word out of a returned doubleword and
// sign- or zero-extends it; shared with the store-forwarding path.
module load_data_align
  import sys_defs::*;
(
  input  logic [63:0]     data,
  input  logic [2:0]      addr,
  input  logic [2:0]      mem_size,
  output logic [XLEN-1:0] result
);

  logic [31:0] word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unsigned_ld;

  always_comb begin
    word        = addr[2] ? data[63:32] : data[31:0];
    byte_sel    = word[{addr[1:0], 3'b000} +: 8];
    half_sel    = addr[1] ? word[31:16] : word[15:0];
    unsigned_ld = mem_size[2];
    case (MEM_SIZE'(mem_size[1:0]))
      BYTE:    result = unsigned_ld ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      HALF:    result = unsigned_ld ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_mem_ctrl.sv
// In-order load queue: issues loads to the data port, captures tagged
// responses out of order, and retires completions to the FU in program order.
module load_mem_ctrl
  import sys_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            squash,
  input  EX_LSQ_PACKET    ex_lsq_load_packet,
  output logic            lq_ready,
  input  logic            mem_grant,
  output BUS_COMMAND      proc2Dmem_command,
  output logic [XLEN-1:0] proc2Dmem_addr,
  input  logic [3:0]      Dmem2proc_response,
  input  logic [63:0]     Dmem2proc_data,
  input  logic [3:0]      Dmem2proc_tag,
  output FU_EX_PACKET     fu_out_packet,
  input  logic            ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   PTR_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] IDX_ONE = PTR_W'(1);

  LQ_ENTRY         entries [DEPTH];
  logic [PTR_W:0]  head, tail;
  logic [PTR_W-1:0] head_idx, tail_idx;
  logic            full, enq, pop;
  FU_EX_PACKET     out_reg, out_next;

  logic             issue_found, issue_go;
  logic [PTR_W-1:0] issue_idx, scan_idx;

  logic [DEPTH-1:0] hit_vec;
  logic             any_hit;
  logic [PTR_W-1:0] hit_idx;
  logic [XLEN-1:0]  hit_data;

  logic [PTR_W-1:0] pres_idx;
  logic             pres_ready;
  logic [XLEN-1:0]  pres_data;

  assign head_idx = head[PTR_W-1:0];
  assign tail_idx = tail[PTR_W-1:0];
  assign full     = (head[PTR_W] != tail[PTR_W]) && (head_idx == tail_idx);
  assign lq_ready = !full;
  assign enq      = ex_lsq_load_packet.valid && !full && !squash;
  assign pop      = out_reg.done && ack;
  assign fu_out_packet = out_reg;

  // Oldest entry still waiting for issue, scanning forward from head.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    scan_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_idx + PTR_W'(i);
      if (!issue_found && entries[scan_idx].valid &&
          entries[scan_idx].state == LQ_WAIT_ISSUE) begin
        issue_found = 1'b1;
        issue_idx   = scan_idx;
      end
    end
  end

  assign issue_go = issue_found && mem_grant && !squash && !reset;

  always_comb begin
    proc2Dmem_command = BUS_NONE;
    proc2Dmem_addr    = '0;
    if (issue_go) begin
      proc2Dmem_command = BUS_LOAD;
      proc2Dmem_addr    = dword_addr(entries[issue_idx].addr);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit_vec[gi] = entries[gi].valid && entries[gi].state == LQ_WAIT_DATA &&
                           Dmem2proc_tag != '0 && entries[gi].mem_tag == Dmem2proc_tag;
    end
  endgenerate

  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        any_hit = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  load_data_align u_align (
    .data     (Dmem2proc_data),
    .addr     (entries[hit_idx].addr[2:0]),
    .mem_size (entries[hit_idx].mem_size),
    .result   (hit_data)
  );

  // The entry that would be presented next; a same-cycle response hit is
  // forwarded so done rises on the edge that captures the data.
  always_comb begin
    pres_idx   = pop ? head_idx + IDX_ONE : head_idx;
    pres_ready = entries[pres_idx].valid &&
                 (entries[pres_idx].state == LQ_DONE || hit_vec[pres_idx]);
    pres_data  = (entries[pres_idx].state == LQ_DONE) ? entries[pres_idx].data : hit_data;
    out_next   = out_reg;
    if (!out_reg.done || pop) begin
      out_next = '0;
      if (pres_ready) begin
        out_next.done    = 1'b1;
        out_next.v       = pres_data;
        out_next.rob_tag = entries[pres_idx].rob_tag;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      out_reg <= '0;
    end else begin
      out_reg <= out_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (squash) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      if (enq) begin
        entries[tail_idx] <= '{valid:    1'b1,
                               addr:     ex_lsq_load_packet.alu_result,
                               mem_size: ex_lsq_load_packet.mem_size,
                               rob_tag:  ex_lsq_load_packet.tag,
                               mem_tag:  '0,
                               data:     '0,
                               state:    LQ_WAIT_ISSUE};
        tail <= tail + PTR_ONE;
      end
      // A zero response means the port rejected us; the entry simply retries.
      if (issue_go && Dmem2proc_response != '0) begin
        entries[issue_idx].mem_tag <= Dmem2proc_response;
        entries[issue_idx].state   <= LQ_WAIT_DATA;
      end
      if (any_hit) begin
        entries[hit_idx].data  <= hit_data;
        entries[hit_idx].state <= LQ_DONE;
      end
      if (pop) begin
        entries[head_idx].valid <= 1'b0;
        head <= head + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_load_mem_ctrl.sv
// Directed bench for load_mem_ctrl with an in-order scoreboard of expected
// completions (value + ROB tag).
module tb_load_mem_ctrl;
  import sys_defs::*;

  logic         clock = 1'b0;
  logic         reset, squash, mem_grant, ack, lq_ready;
  EX_LSQ_PACKET pkt;
  BUS_COMMAND   cmd;
  logic [31:0]  maddr;
  logic [3:0]   resp, dtag;
  logic [63:0]  ddata;
  FU_EX_PACKET  fu;

  typedef struct {
    logic [31:0] v;
    logic [4:0]  rob;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  load_mem_ctrl #(.DEPTH(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .squash             (squash),
    .ex_lsq_load_packet (pkt),
    .lq_ready           (lq_ready),
    .mem_grant          (mem_grant),
    .proc2Dmem_command  (cmd),
    .proc2Dmem_addr     (maddr),
    .Dmem2proc_response (resp),
    .Dmem2proc_data     (ddata),
    .Dmem2proc_tag      (dtag),
    .fu_out_packet      (fu),
    .ack                (ack)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [2:0] sz, input logic [4:0] rob,
                     input logic [31:0] v, input bit push);
    if (push) check("lq_ready_before_enq", lq_ready, 1);
    pkt = '{valid: 1'b1, alu_result: a, mem_size: sz, tag: rob};
    if (push) sb.push_back('{v: v, rob: rob});
    step();
    pkt.valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] r, input logic [31:0] exp_addr);
    mem_grant = 1'b1;
    resp      = r;
    #1;
    check("issue_cmd", cmd, BUS_LOAD);
    check("issue_addr", maddr, exp_addr);
    step();
    mem_grant = 1'b0;
    resp      = '0;
  endtask

  task automatic ret(input logic [3:0] t, input logic [63:0] d);
    dtag  = t;
    ddata = d;
    step();
    dtag  = '0;
  endtask

  task automatic complete();
    int   cnt;
    exp_t e;
    cnt = 0;
    while (!fu.done && cnt < 20) begin
      step();
      cnt++;
    end
    check("done_timeout", fu.done, 1);
    check("sb_nonempty", sb.size() != 0, 1);
    if (fu.done && sb.size() != 0) begin
      e = sb.pop_front();
      check("cpl_v", fu.v, e.v);
      check("cpl_rob", fu.rob_tag, e.rob);
      step();
      check("hold_done", fu.done, 1);
      check("hold_v", fu.v, e.v);
      check("hold_rob", fu.rob_tag, e.rob);
      $display("completion rob=%0d v=0x%08h", fu.rob_tag, fu.v);
      ack = 1'b1;
      step();
      ack = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; mem_grant = 1'b0; ack = 1'b0;
    pkt = '0; resp = '0; dtag = '0; ddata = '0;
    step(); step();
    reset = 1'b0;
    check("rst_lq_ready", lq_ready, 1);
    check("rst_cmd", cmd, BUS_NONE);
    check("rst_addr", maddr, 0);
    check("rst_fu", fu, 0);

    // Single load with minimum latency
    enq(32'h1004, 3'b010, 5'd5, 32'hDEADBEEF, 1);
    issue(4'd3, 32'h1000);
    ret(4'd3, 64'hDEADBEEF_12345678);
    check("lat_done", fu.done, 1);
    complete();

    // Extension cases
    enq(32'h1003, 3'b000, 5'd6, 32'hFFFFFF80, 1);
    issue(4'd4, 32'h1000);
    ret(4'd4, 64'h00000000_80000000);
    complete();
    enq(32'h1003, 3'b100, 5'd7, 32'h00000080, 1);
    issue(4'd5, 32'h1000);
    ret(4'd5, 64'h00000000_80000000);
    complete();
    enq(32'h1002, 3'b001, 5'd8, 32'hFFFF8001, 1);
    issue(4'd6, 32'h1000);
    ret(4'd6, 64'h00000000_80010000);
    complete();

    // Out-of-order return, in-order completion
    enq(32'h2000, 3'b010, 5'd0, 32'h11111111, 1);
    enq(32'h2008, 3'b010, 5'd1, 32'h22222222, 1);
    enq(32'h2014, 3'b010, 5'd2, 32'h33333333, 1);
    issue(4'd1, 32'h2000);
    issue(4'd2, 32'h2008);
    issue(4'd3, 32'h2010);
    ret(4'd3, 64'h33333333_00000000);
    check("ooo_not_done", fu.done, 0);
    ret(4'd1, 64'h00000000_11111111);
    ret(4'd2, 64'h00000000_22222222);
    complete(); complete(); complete();

    // Rejections and a grant gap before acceptance
    enq(32'h3010, 3'b010, 5'd9, 32'h0BADF00D, 1);
    mem_grant = 1'b1; resp = '0;
    #1; check("rej1_cmd", cmd, BUS_LOAD); check("rej1_addr", maddr, 32'h3010);
    step();
    check("rej2_cmd", cmd, BUS_LOAD); check("rej2_addr", maddr, 32'h3010);
    step();
    mem_grant = 1'b0;
    #1; check("nogrant_cmd", cmd, BUS_NONE);
    step();
    issue(4'd5, 32'h3010);
    ret(4'd5, 64'h00000000_0BADF00D);
    complete();
    repeat (3) step();
    check("single_cpl", fu.done, 0);

    // Full queue
    enq(32'h5000, 3'b010, 5'd10, 32'hA0000000, 1);
    enq(32'h5008, 3'b010, 5'd11, 32'hA0000001, 1);
    enq(32'h5010, 3'b010, 5'd12, 32'hA0000002, 1);
    enq(32'h5018, 3'b010, 5'd13, 32'hA0000003, 1);
    check("full_lq_ready", lq_ready, 0);
    enq(32'h5020, 3'b010, 5'd14, 32'hA0000004, 0);
    issue(4'd1, 32'h5000);
    issue(4'd2, 32'h5008);
    issue(4'd3, 32'h5010);
    issue(4'd4, 32'h5018);
    mem_grant = 1'b1; #1;
    check("fifth_not_issued", cmd, BUS_NONE);
    mem_grant = 1'b0;
    ret(4'd1, 64'h00000000_A0000000);
    ret(4'd2, 64'h00000000_A0000001);
    ret(4'd3, 64'h00000000_A0000002);
    ret(4'd4, 64'h00000000_A0000003);
    complete();
    check("after_ack_lq_ready", lq_ready, 1);
    complete(); complete(); complete();
    repeat (4) step();
    check("fifth_dropped", fu.done, 0);

    // Squash with two loads in flight
    enq(32'h4000, 3'b010, 5'd15, 32'h0, 0);
    enq(32'h4008, 3'b010, 5'd16, 32'h0, 0);
    issue(4'd6, 32'h4000);
    issue(4'd7, 32'h4008);
    squash = 1'b1; mem_grant = 1'b1;
    #1; check("squash_cmd", cmd, BUS_NONE);
    step();
    squash = 1'b0; mem_grant = 1'b0;
    check("squash_lq_ready", lq_ready, 1);
    check("squash_done", fu.done, 0);
    ret(4'd6, 64'hFFFFFFFF_FFFFFFFF);
    ret(4'd7, 64'hFFFFFFFF_FFFFFFFF);
    repeat (2) step();
    check("squash_tags_dropped", fu.done, 0);
    enq(32'h4004, 3'b010, 5'd17, 32'hCAFEF00D, 1);
    issue(4'd8, 32'h4000);
    ret(4'd8, 64'hCAFEF00D_00000000);
    complete();

    // Reset mid-operation
    enq(32'h6000, 3'b010, 5'd18, 32'h0, 0);
    issue(4'd9, 32'h6000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_lq_ready", lq_ready, 1);
    check("mrst_fu", fu, 0);
    mem_grant = 1'b1; #1;
    check("mrst_cmd", cmd, BUS_NONE);
    mem_grant = 1'b0;
    ret(4'd9, 64'h12345678_12345678);
    step();
    check("mrst_tag_dropped", fu.done, 0);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
